// File: rtl/enc_block_ctrl.sv
// enc_block_ctrl: sequencing controller for the turbo-encoder block counter
// and datapath. Accepts a block-start request, latches the block-size mode,
// clears the encoder counter, then steps it through the data bits and the
// trellis-termination tail. It drives the tail switch, the output-valid flag
// and a one-cycle done pulse.
//
// Ports:
//   clk        clock, all logic on rising edge
//   clr_n      synchronous active-low reset; forces every output to 0 while low
//   start      block start request, accepted when start & ready
//   mode       block size select sampled at accept (0=LONG_K, 1=SHORT_K)
//   src_valid  upstream data bit valid this cycle
//   abort      synchronous block abort (ignored in IDLE)
//   ready      controller idle, can accept start
//   enc_en     encoder/counter enable
//   cnt_clr    one-cycle clear to encoder counter/state
//   sw         tail switch, 1 = feedback/tail path selected
//   out_valid  encoder output valid
//   blk_done   one-cycle pulse at end of block
//   cnt        current cycle index within block
//   mode_q     latched mode of block in progress
//
// State   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start, ready=1
// S_CLEAR | one cycle, clears encoder counter/state
// S_DATA  | data bits, counter advances on src_valid only
// S_TAIL  | trellis-termination tail, counter advances every cycle
// S_DONE  | one cycle, blk_done pulse

module enc_block_ctrl #(
  parameter int CNT_W    = 13,
  parameter int LONG_K   = 6144,
  parameter int SHORT_K  = 1056,
  parameter int TAIL_LEN = 4,
  parameter int PIPE_LAT = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             mode,
  input  logic             src_valid,
  input  logic             abort,
  output logic             ready,
  output logic             enc_en,
  output logic             cnt_clr,
  output logic             sw,
  output logic             out_valid,
  output logic             blk_done,
  output logic [CNT_W-1:0] cnt,
  output logic             mode_q
);

  if (LONG_K + TAIL_LEN > (1 << CNT_W)) begin : g_chk_cnt_w
    $error("enc_block_ctrl: CNT_W too narrow for LONG_K+TAIL_LEN-1");
  end
  if (SHORT_K < 2) begin : g_chk_short_k
    $error("enc_block_ctrl: SHORT_K must be at least 2");
  end
  if (PIPE_LAT >= SHORT_K) begin : g_chk_pipe_lat
    $error("enc_block_ctrl: PIPE_LAT must be below SHORT_K");
  end

  localparam logic [CNT_W-1:0] LONG_LAST       = CNT_W'(LONG_K - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST      = CNT_W'(SHORT_K - 1);
  localparam logic [CNT_W-1:0] LONG_TAIL_LAST  = CNT_W'(LONG_K + TAIL_LEN - 1);
  localparam logic [CNT_W-1:0] SHORT_TAIL_LAST = CNT_W'(SHORT_K + TAIL_LEN - 1);
  localparam logic [CNT_W-1:0] PIPE_C          = CNT_W'(PIPE_LAT);
  localparam logic [CNT_W-1:0] ONE             = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DATA,
    S_TAIL,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_r, mode_d;

  logic             rdy_c, en_c, clr_c, sw_c, done_c, ov_c;
  logic [CNT_W-1:0] data_last, tail_last;

  assign data_last = mode_r ? SHORT_LAST : LONG_LAST;
  assign tail_last = mode_r ? SHORT_TAIL_LAST : LONG_TAIL_LAST;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_r  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_r  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_r;
    rdy_c   = 1'b0;
    en_c    = 1'b0;
    clr_c   = 1'b0;
    sw_c    = 1'b0;
    done_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        rdy_c = 1'b1;
        if (start) begin
          mode_d  = mode;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        clr_c   = 1'b1;
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        en_c = src_valid;
        // switch closes on the last data index even while that bit stalls
        sw_c = (cnt_q == data_last);
        if (src_valid) begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == data_last) state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        en_c = 1'b1;
        sw_c = 1'b1;
        // counter stops on the last tail index so it never exceeds K+TAIL_LEN-1
        if (cnt_q == tail_last) state_d = S_DONE;
        else                    cnt_d   = cnt_q + ONE;
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // abort overrides every transition, including the done pulse
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      clr_c   = 1'b1;
      done_c  = 1'b0;
    end
  end

  assign ov_c = ((state_q == S_DATA) || (state_q == S_TAIL)) && en_c && (cnt_q > PIPE_C);

  // everything is held at 0 while reset is asserted
  assign ready     = clr_n & rdy_c;
  assign enc_en    = clr_n & en_c;
  assign cnt_clr   = clr_n & clr_c;
  assign sw        = clr_n & sw_c;
  assign out_valid = clr_n & ov_c;
  assign blk_done  = clr_n & done_c;
  assign cnt       = clr_n ? cnt_q : '0;
  assign mode_q    = clr_n & mode_r;

endmodule

// File: tb/tb_enc_block_ctrl.sv
module tb_enc_block_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_n;

  logic       s_start, s_mode, s_src_valid, s_abort;
  logic       s_ready, s_enc_en, s_cnt_clr, s_sw, s_out_valid, s_blk_done, s_mode_q;
  logic [3:0] s_cnt;

  logic        d_start, d_mode, d_src_valid, d_abort;
  logic        d_ready, d_enc_en, d_cnt_clr, d_sw, d_out_valid, d_blk_done, d_mode_q;
  logic [12:0] d_cnt;

  int total = 0;
  int bad   = 0;

  enc_block_ctrl #(
    .CNT_W(4), .LONG_K(8), .SHORT_K(4), .TAIL_LEN(4), .PIPE_LAT(2)
  ) u_small (
    .clk(clk), .clr_n(clr_n), .start(s_start), .mode(s_mode),
    .src_valid(s_src_valid), .abort(s_abort), .ready(s_ready),
    .enc_en(s_enc_en), .cnt_clr(s_cnt_clr), .sw(s_sw),
    .out_valid(s_out_valid), .blk_done(s_blk_done), .cnt(s_cnt),
    .mode_q(s_mode_q)
  );

  enc_block_ctrl u_dflt (
    .clk(clk), .clr_n(clr_n), .start(d_start), .mode(d_mode),
    .src_valid(d_src_valid), .abort(d_abort), .ready(d_ready),
    .enc_en(d_enc_en), .cnt_clr(d_cnt_clr), .sw(d_sw),
    .out_valid(d_out_valid), .blk_done(d_blk_done), .cnt(d_cnt),
    .mode_q(d_mode_q)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // c < 0 skips the counter check
  task automatic chk_s(input string tag, input logic rdy, input logic clr, input logic en,
                       input logic swx, input logic ov, input logic dn, input int c);
    chk1({tag, ".ready"},     s_ready,     rdy);
    chk1({tag, ".cnt_clr"},   s_cnt_clr,   clr);
    chk1({tag, ".enc_en"},    s_enc_en,    en);
    chk1({tag, ".sw"},        s_sw,        swx);
    chk1({tag, ".out_valid"}, s_out_valid, ov);
    chk1({tag, ".blk_done"},  s_blk_done,  dn);
    if (c >= 0) chkn({tag, ".cnt"}, int'(s_cnt), c);
  endtask

  // One block on the small instance (TAIL_LEN=4, PIPE_LAT=2).
  // done_cyc is the hand-computed cycle (accept = cycle 0) of blk_done.
  task automatic run_blk(input logic m, input int k, input int st_at, input int st_len,
                         input int done_cyc, input logic ab0, input logic hold);
    int   e_cnt;
    int   ph;
    int   stl;
    logic sv;
    @(negedge clk);
    s_start = 1'b1; s_mode = m; s_src_valid = 1'b1; s_abort = ab0;
    #1;
    chk1("accept.ready", s_ready, 1'b1);
    ph = 0; e_cnt = 0; stl = st_len;
    for (int c = 1; c <= 100 && ph != 4; c++) begin
      @(negedge clk);
      s_start = hold; s_mode = ~m; s_abort = 1'b0;
      sv = 1'b1;
      if (ph == 1 && e_cnt == st_at && stl > 0) begin
        sv = 1'b0;
        stl--;
      end
      s_src_valid = sv;
      #1;
      case (ph)
        0: chk_s("clear", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        1: chk_s("data", 1'b0, 1'b0, sv, (e_cnt == k - 1), (sv && e_cnt > 2), 1'b0, e_cnt);
        2: chk_s("tail", 1'b0, 1'b0, 1'b1, 1'b1, (e_cnt > 2), 1'b0, e_cnt);
        default: chk_s("done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e_cnt);
      endcase
      chk1("sched.blk_done", s_blk_done, (c == done_cyc));
      chk1("mode_q", s_mode_q, m);
      case (ph)
        0: begin ph = 1; e_cnt = 0; end
        1: if (sv) begin
             if (e_cnt == k - 1) ph = 2;
             e_cnt++;
           end
        2: if (e_cnt == k + 3) ph = 3; else e_cnt++;
        default: ph = 4;
      endcase
    end
    chkn("blk.finished", ph, 4);
    @(negedge clk);
    s_start = 1'b0; s_src_valid = 1'b0;
    #1;
    chk_s("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, k + 3);
  endtask

  task automatic run_big(input logic m, input int sw_exp, input int done_exp);
    int sw_cnt;
    int done_c;
    @(negedge clk);
    d_start = 1'b1; d_mode = m; d_src_valid = 1'b1;
    sw_cnt = -1; done_c = -1;
    for (int c = 1; c <= 7000 && done_c < 0; c++) begin
      @(negedge clk);
      d_start = 1'b0;
      #1;
      if (d_sw && sw_cnt < 0) sw_cnt = int'(d_cnt);
      if (d_blk_done) done_c = c;
    end
    chkn("big.sw_first_cnt", sw_cnt, sw_exp);
    chkn("big.done_cycle", done_c, done_exp);
    @(negedge clk);
    d_src_valid = 1'b0;
    #1;
    chk1("big.ready", d_ready, 1'b1);
  endtask

  initial begin
    clr_n = 1'b0;
    s_start = 1'b0; s_mode = 1'b0; s_src_valid = 1'b0; s_abort = 1'b0;
    d_start = 1'b0; d_mode = 1'b0; d_src_valid = 1'b0; d_abort = 1'b0;

    // reset
    @(negedge clk);
    @(negedge clk);
    #1;
    chk1("rst.ready", s_ready, 1'b0);
    chkn("rst.cnt", int'(s_cnt), 0);
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    chk_s("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk1("post_rst.mode_q", s_mode_q, 1'b0);

    // short block, long block, long block with a 3-cycle stall at cnt=5
    run_blk(1'b1, 4, -1, 0, 10, 1'b0, 1'b0);
    run_blk(1'b0, 8, -1, 0, 14, 1'b0, 1'b0);
    run_blk(1'b0, 8, 5, 3, 17, 1'b0, 1'b0);

    // abort at cnt=6 in TAIL of a short block
    @(negedge clk);
    s_start = 1'b1; s_mode = 1'b1; s_src_valid = 1'b1; s_abort = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      s_start = 1'b0;
    end
    @(negedge clk);
    s_abort = 1'b1;
    #1;
    chkn("abort.cnt", int'(s_cnt), 6);
    chk1("abort.cnt_clr", s_cnt_clr, 1'b1);
    chk1("abort.blk_done", s_blk_done, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      s_abort = 1'b0;
      #1;
      chk_s("after_abort", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
    // abort asserted in IDLE together with start: start still accepted
    run_blk(1'b1, 4, -1, 0, 10, 1'b1, 1'b0);

    // reset for two cycles mid-DATA
    @(negedge clk);
    s_start = 1'b1; s_mode = 1'b1; s_src_valid = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      clr_n = 1'b0;
      #1;
      chk_s("in_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      chk1("in_rst.mode_q", s_mode_q, 1'b0);
    end
    @(negedge clk);
    clr_n = 1'b1; s_start = 1'b0; s_src_valid = 1'b0;
    #1;
    chk_s("rst_release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk1("rst_release.mode_q", s_mode_q, 1'b0);

    // start held high for the whole block: only one block runs
    run_blk(1'b0, 8, -1, 0, 14, 1'b0, 1'b1);

    // default-parameter instance
    run_big(1'b0, 6143, 6150);
    run_big(1'b1, 1055, 1062);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
